// File: rtl/axi_wr_burst_splitter.sv
// axi_wr_burst_splitter: splits one long write transfer (start address +
// total beat count) into AXI INCR bursts of at most MAX_BURST beats that
// never cross a BOUNDARY-byte boundary, and issues them one at a time to the
// downstream write core.
//
// Handshakes:
//   cmd    : a command is taken on a rising clock edge where cmd_valid and
//            cmd_ready are both 1; cmd_ready is low from accept until the
//            cycle after cmd_done, so offers while busy are simply not taken.
//   write  : write_req rises with a stable req_addr/req_len and stays high
//            until req_resp is sampled 1; req_addr/req_len then stay stable
//            until req_done is sampled 1. A req_resp+req_done pair in the same
//            REQ cycle counts as response followed by completion.
module axi_wr_burst_splitter #(
  parameter int ASIZE      = 32,
  parameter int LSIZE      = 10,
  parameter int TSIZE      = 24,
  parameter int BEAT_BYTES = 32,
  parameter int MAX_BURST  = 256,
  parameter int BOUNDARY   = 4096
) (
  input  logic             axi_aclk,
  input  logic             axi_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ASIZE-1:0] cmd_addr,
  input  logic [TSIZE-1:0] cmd_beats,
  input  logic             cmd_abort,
  output logic             cmd_done,
  output logic             busy,
  output logic [15:0]      burst_cnt,
  output logic             write_req,
  output logic [LSIZE-1:0] req_len,
  output logic [ASIZE-1:0] req_addr,
  input  logic             req_resp,
  input  logic             req_done,
  output logic [2:0]       state_dbg
);

  localparam int BND_W  = $clog2(BOUNDARY);
  localparam int BEAT_W = $clog2(BEAT_BYTES);
  // Comparison width for min(remain, MAX_BURST, to_bnd); wide enough for all.
  localparam int CW     = (TSIZE > 31) ? TSIZE + 1 : 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CALC      = 3'd1,
    REQ       = 3'd2,
    WAIT_DONE = 3'd3,
    FIN       = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ASIZE-1:0]   cur_addr_q, cur_addr_d;
  logic [TSIZE-1:0]   remain_q, remain_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               cmd_done_q, cmd_done_d;
  logic               busy_q, busy_d;
  logic [15:0]        burst_cnt_q, burst_cnt_d;
  logic               write_req_q, write_req_d;
  logic [LSIZE-1:0]   req_len_q, req_len_d;
  logic [ASIZE-1:0]   req_addr_q, req_addr_d;
  logic               abort_pend_q, abort_pend_d;

  logic [BND_W-1:0]   bnd_off;
  logic [CW-1:0]      to_bnd;
  logic [CW-1:0]      len_calc;
  logic               abort_now;
  logic               do_complete;

  assign bnd_off = cur_addr_q[BND_W-1:0];

  // Burst length: the smallest of remaining beats, MAX_BURST and beats left
  // before the next boundary (at least 1 since cur_addr is beat aligned).
  always_comb begin
    to_bnd   = (CW'(BOUNDARY) - CW'(bnd_off)) >> BEAT_W;
    len_calc = CW'(remain_q);
    if (CW'(MAX_BURST) < len_calc) len_calc = CW'(MAX_BURST);
    if (to_bnd < len_calc)         len_calc = to_bnd;
  end

  // Next-state and registered-output logic for the burst sequencer.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remain_d     = remain_q;
    cmd_ready_d  = cmd_ready_q;
    cmd_done_d   = cmd_done_q;
    busy_d       = busy_q;
    burst_cnt_d  = burst_cnt_q;
    write_req_d  = write_req_q;
    req_len_d    = req_len_q;
    req_addr_d   = req_addr_q;
    abort_pend_d = abort_pend_q;
    abort_now    = abort_pend_q | cmd_abort;
    do_complete  = 1'b0;

    if (state_q != IDLE && cmd_abort) abort_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cur_addr_d  = cmd_addr;
          remain_d    = cmd_beats;
          busy_d      = 1'b1;
          cmd_ready_d = 1'b0;
          burst_cnt_d = 16'd0;
          if (cmd_beats == '0) begin
            state_d    = FIN;
            cmd_done_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (abort_now) begin
          state_d    = FIN;
          cmd_done_d = 1'b1;
        end else begin
          req_len_d   = LSIZE'(len_calc);
          req_addr_d  = cur_addr_q;
          write_req_d = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (req_resp) begin
          write_req_d = 1'b0;
          burst_cnt_d = burst_cnt_q + 16'd1;
          if (req_done) do_complete = 1'b1;
          else          state_d     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (req_done) do_complete = 1'b1;
      end
      FIN: begin
        cmd_done_d   = 1'b0;
        busy_d       = 1'b0;
        cmd_ready_d  = 1'b1;
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Burst completion: advance the address (wrapping in ASIZE bits) and
    // retire the burst's beats; stop when nothing is left or an abort waits.
    if (do_complete) begin
      cur_addr_d = cur_addr_q + (ASIZE'(req_len_q) << BEAT_W);
      remain_d   = remain_q - TSIZE'(req_len_q);
      if (remain_d == '0 || abort_now) begin
        state_d    = FIN;
        cmd_done_d = 1'b1;
      end else begin
        state_d = CALC;
      end
    end
  end

  // State and output registers; reset drops write_req immediately.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remain_q     <= '0;
      cmd_ready_q  <= 1'b1;
      cmd_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      burst_cnt_q  <= 16'd0;
      write_req_q  <= 1'b0;
      req_len_q    <= '0;
      req_addr_q   <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remain_q     <= remain_d;
      cmd_ready_q  <= cmd_ready_d;
      cmd_done_q   <= cmd_done_d;
      busy_q       <= busy_d;
      burst_cnt_q  <= burst_cnt_d;
      write_req_q  <= write_req_d;
      req_len_q    <= req_len_d;
      req_addr_q   <= req_addr_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_done  = cmd_done_q;
  assign busy      = busy_q;
  assign burst_cnt = burst_cnt_q;
  assign write_req = write_req_q;
  assign req_len   = req_len_q;
  assign req_addr  = req_addr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_axi_wr_burst_splitter.sv
// Testbench for axi_wr_burst_splitter: table of directed commands, hand-built
// abort/reset sequences and randomized commands, all checked against a
// burst-list reference model and a cycle-level downstream responder.
module tb_axi_wr_burst_splitter;

  localparam int BEAT_BYTES = 32;
  localparam int MAX_BURST  = 256;
  localparam int BOUNDARY   = 4096;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_abort, cmd_done, busy;
  logic [31:0] cmd_addr;
  logic [23:0] cmd_beats;
  logic [15:0] burst_cnt;
  logic        write_req, req_resp, req_done;
  logic [9:0]  req_len;
  logic [31:0] req_addr;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  axi_wr_burst_splitter dut (
    .axi_aclk  (clk),
    .axi_reset (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_beats (cmd_beats),
    .cmd_abort (cmd_abort),
    .cmd_done  (cmd_done),
    .busy      (busy),
    .burst_cnt (burst_cnt),
    .write_req (write_req),
    .req_len   (req_len),
    .req_addr  (req_addr),
    .req_resp  (req_resp),
    .req_done  (req_done),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [41:0] exp_q[$];   // {addr, len} of each expected burst
  logic [41:0] obs_q[$];   // {addr, len} of each burst seen

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: walk the transfer with plain arithmetic.
  task automatic model_bursts(input logic [31:0] a, input int beats, input int abort_k);
    longint addr;
    int     rem, len, to_bnd, k;
    addr = longint'(a);
    rem  = beats;
    k    = 0;
    exp_q.delete();
    while (rem > 0 && !(abort_k > 0 && k >= abort_k)) begin
      to_bnd = int'((BOUNDARY - (addr % BOUNDARY)) / BEAT_BYTES);
      len = rem;
      if (len > MAX_BURST) len = MAX_BURST;
      if (to_bnd < len)    len = to_bnd;
      exp_q.push_back({addr[31:0], 10'(len)});
      addr = (addr + longint'(len) * BEAT_BYTES) % 64'h1_0000_0000;
      rem -= len;
      k++;
    end
  endtask

  // ---------------- driver + downstream responder ----------------
  // rd: cycles write_req is left waiting before req_resp; dd: cycles from
  // req_resp to req_done (0 = same cycle); abort_k: abort during burst k.
  task automatic run_cmd(input logic [31:0] addr, input logic [23:0] beats, input int rd,
                         input int dd, input int abort_k, input bit noise);
    int          cyc, phase, cnt, nb, last_ev, budget, exp_n;
    bit          seen_done;
    logic [31:0] cur_a;
    logic [9:0]  cur_l;
    logic [41:0] e;
    model_bursts(addr, int'(beats), abort_k);
    exp_n  = exp_q.size();
    obs_q.delete();
    budget = 50 + (exp_n + 1) * (rd + dd + 8);
    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_beats = beats;
    cyc = 0; phase = 0; cnt = 0; nb = 0; last_ev = 0; seen_done = 0;
    cur_a = '0; cur_l = '0;
    while (!seen_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      req_resp = 1'b0; req_done = 1'b0; cmd_abort = 1'b0;
      cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_addr  = $urandom;
      cmd_beats = 24'($urandom);
      if (cyc == 1) begin
        check("busy_after_accept", busy, 1);
        check("ready_low_busy", cmd_ready, 0);
        check("burst_cnt_cleared", burst_cnt, 0);
      end
      if (cmd_done) begin
        seen_done = 1;
        cmd_valid = 1'b0;
        check("done_latency", cyc, last_ev + 1);
        check("done_burst_cnt", burst_cnt, exp_n);
        check("done_no_req", write_req, 0);
      end else if (phase == 2) begin
        check("wr_dropped", write_req, 0);
        check("hold_addr", req_addr, cur_a);
        check("hold_len", req_len, cur_l);
        check("cnt_in_flight", burst_cnt, nb);
        cnt++;
        if (cnt == 1 && nb == abort_k) cmd_abort = 1'b1;
        if (cnt >= dd) begin
          req_done = 1'b1; last_ev = cyc; phase = 0;
        end else if (noise && $urandom_range(0, 2) == 0) begin
          req_resp = 1'b1;   // stray response outside REQ
        end
      end else begin
        if (phase == 0) begin
          if (write_req) begin
            check("req_latency", cyc, last_ev + 2);
            cur_a = req_addr; cur_l = req_len; nb++;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL extra_burst: got addr 0x%0h len %0d, expected no burst", req_addr, req_len);
            end else begin
              e = exp_q.pop_front();
              check("burst_addr", req_addr, e[41:10]);
              check("burst_len", req_len, e[9:0]);
            end
            obs_q.push_back({req_addr, req_len});
            phase = 1; cnt = 0;
          end else if (noise) begin
            req_resp = 1'($urandom_range(0, 1));
            req_done = 1'($urandom_range(0, 1));
          end
        end
        if (phase == 1) begin
          check("req_held", write_req, 1);
          check("req_addr_stable", req_addr, cur_a);
          check("req_len_stable", req_len, cur_l);
          if (cnt == rd) begin
            req_resp = 1'b1;
            if (dd == 0) begin
              req_done = 1'b1; last_ev = cyc; phase = 0;
              if (nb == abort_k) cmd_abort = 1'b1;
            end else begin
              phase = 2; cnt = 0;
            end
          end else begin
            cnt++;
            if (noise && $urandom_range(0, 2) == 0) req_done = 1'b1;  // stray done in REQ
          end
        end
      end
    end
    cmd_valid = 1'b0; req_resp = 1'b0; req_done = 1'b0; cmd_abort = 1'b0;
    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: got no cmd_done within %0d cycles, expected one", budget);
    end
    check("all_bursts_issued", exp_q.size(), 0);
    @(negedge clk);
    check("done_single_pulse", cmd_done, 0);
    check("busy_clear", busy, 0);
    check("ready_back", cmd_ready, 1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] addr;
    int          beats;
    int          rd;
    int          dd;
    int          abort_k;
    int          exp_n;
    int          exp_len0;
    int          exp_len1;
    logic [31:0] exp_addr1;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [41:0] b0, b1;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; cmd_abort = 1'b0;
    req_resp = 1'b0; req_done = 1'b0;

    vecs[0] = '{32'h0000_0000, 512, 0, 1, 0, 4, 128, 128, 32'h0000_1000};
    vecs[1] = '{32'h0000_0F80,  10, 1, 2, 0, 2,   4,   6, 32'h0000_1000};
    vecs[2] = '{32'h0000_0100,   3, 0, 1, 0, 1,   3,   0, 32'h0000_0000};
    vecs[3] = '{32'h0000_0000, 512, 20, 3, 0, 4, 128, 128, 32'h0000_1000};
    vecs[4] = '{32'h0000_0000, 512, 1, 3, 2, 2, 128, 128, 32'h0000_1000};
    vecs[5] = '{32'h0000_5000,   0, 0, 1, 0, 0,   0,   0, 32'h0000_0000};
    vecs[6] = '{32'h0000_0FE0, 130, 2, 1, 0, 3,   1, 128, 32'h0000_1000};
    vecs[7] = '{32'hFFFF_FFC0,   4, 0, 2, 0, 2,   2,   2, 32'h0000_0000};
    vecs[8] = '{32'h0000_0040, 200, 0, 0, 0, 2, 126,  74, 32'h0000_1000};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_write_req", write_req, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_busy", busy, 0);
    check("rst_burst_cnt", burst_cnt, 0);
    check("rst_req_len", req_len, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].addr, 24'(vecs[i].beats), vecs[i].rd, vecs[i].dd, vecs[i].abort_k, 1'b0);
      check("vec_n_bursts", obs_q.size(), vecs[i].exp_n);
      check("vec_final_cnt", burst_cnt, vecs[i].exp_n);
      b0 = (obs_q.size() > 0) ? obs_q[0] : '0;
      b1 = (obs_q.size() > 1) ? obs_q[1] : '0;
      if (vecs[i].exp_n >= 1) begin
        check("vec_addr0", b0[41:10], vecs[i].addr);
        check("vec_len0", b0[9:0], vecs[i].exp_len0);
      end
      if (vecs[i].exp_n >= 2) begin
        check("vec_addr1", b1[41:10], vecs[i].exp_addr1);
        check("vec_len1", b1[9:0], vecs[i].exp_len1);
      end
    end

    // Abort while in CALC: straight to FIN, no write_req, one cmd_done.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h0; cmd_beats = 24'd512;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_abort = 1'b1;
    check("calc_abort_state", state_dbg, 1);
    @(negedge clk);
    cmd_abort = 1'b0;
    check("calc_abort_done", cmd_done, 1);
    check("calc_abort_no_req", write_req, 0);
    check("calc_abort_cnt", burst_cnt, 0);
    @(negedge clk);
    check("calc_abort_pulse", cmd_done, 0);
    check("calc_abort_no_req2", write_req, 0);
    check("calc_abort_ready", cmd_ready, 1);

    // Abort in IDLE is ignored: the following command runs in full.
    cmd_abort = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_state", state_dbg, 0);
    cmd_abort = 1'b0;
    run_cmd(32'h0000_0100, 24'd3, 0, 1, 0, 1'b0);
    check("idle_abort_bursts", obs_q.size(), 1);

    // Reset while write_req is pending.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h0; cmd_beats = 24'd512;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int w = 0; w < 10 && !write_req; w++) @(negedge clk);
    check("pre_reset_req", write_req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", write_req, 0);
    check("async_rst_ready", cmd_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_cnt", burst_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    run_cmd(32'h0000_0100, 24'd3, 0, 2, 0, 1'b0);
    check("post_rst_bursts", obs_q.size(), 1);

    // Randomized commands with stray handshake pulses and busy-time offers.
    for (int t = 0; t < 30; t++) begin
      logic [31:0] r, a;
      int          bts, rd, dd, ak;
      r = $urandom;
      if ($urandom_range(0, 2) == 0)
        a = (r & 32'hFFFF_F000) | (32'h0000_0FE0 - (32'($urandom_range(0, 7)) << 5));
      else
        a = r & 32'hFFFF_FFE0;
      bts = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 600));
      rd  = int'($urandom_range(0, 3));
      dd  = int'($urandom_range(0, 3));
      ak  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_cmd(a, 24'(bts), rd, dd, ak, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "time limit");
  end

endmodule
